irq_dispatch: RTL and testbench



---
 rtl/irq_pkg.sv | 15 +
 rtl/irq_sync.sv | 26 ++
 rtl/irq_dispatch.sv | 106 ++++++++++
 tb/tb_irq_dispatch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt dispatcher.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SERV = 2'd2
  } irq_state_e;

  localparam int WIDTH_OUT_DEF   = 3;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/irq_sync.sv
// N-stage multi-bit synchronizer with asynchronous reset to a fixed value.
module irq_sync #(
  parameter int           W       = 4,
  parameter int           STAGES  = 2,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_bar,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync_p [STAGES];

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      for (int i = 0; i < STAGES; i++) sync_p[i] <= RST_VAL;
    end else begin
      sync_p[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/irq_dispatch.sv
// Interrupt dispatcher behind an active-low 8-to-3 priority encoder: sync, latch, req/ack, in-service tracking.
// Optional glitch filter (two matching synchronized samples) enabled by defining IRQ_FILTER_EN.
module irq_dispatch
  import irq_pkg::*;
#(
  parameter int WIDTH_OUT   = WIDTH_OUT_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_bar,
  input  logic                 GS_bar,
  input  logic [WIDTH_OUT-1:0] Y_bar,
  input  logic                 int_ack,
  input  logic                 int_done,
  output logic                 int_req,
  output logic [WIDTH_OUT-1:0] int_vec,
  output logic                 in_service
);

  localparam int BUS_W  = WIDTH_OUT + 1;
  localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                          (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : SYNC_STAGES;

  logic [BUS_W-1:0]     sync_bus;
  logic                 valid_s;
  logic [WIDTH_OUT-1:0] code_s;
  logic                 accept;

  irq_sync #(
    .W      (BUS_W),
    .STAGES (SYNC_N),
    .RST_VAL({BUS_W{1'b1}})
  ) u_sync (
    .clk    (clk),
    .rst_bar(rst_bar),
    .d      ({GS_bar, Y_bar}),
    .q      (sync_bus)
  );

  assign valid_s = ~sync_bus[WIDTH_OUT];
  assign code_s  = ~sync_bus[WIDTH_OUT-1:0];

`ifdef IRQ_FILTER_EN
  // Previous synchronized sample; equality with an active sample implies both were active.
  logic [BUS_W-1:0] sync_prev_p;

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) sync_prev_p <= '1;
    else          sync_prev_p <= sync_bus;
  end

  assign accept = valid_s && (sync_prev_p == sync_bus);
`else
  assign accept = valid_s;
`endif

  irq_state_e state, state_nxt;
  logic       load_vec;
  logic       cooldown;

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      state    <= IDLE;
      int_vec  <= '0;
      cooldown <= 1'b0;
    end else begin
      state    <= state_nxt;
      // Forces one extra IDLE cycle after service so a held request is not re-latched at once.
      cooldown <= (state == SERV) && int_done;
      if (load_vec) int_vec <= code_s;
    end
  end

  always_comb begin
    state_nxt = state;
    load_vec  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !cooldown) begin
          state_nxt = PEND;
          load_vec  = 1'b1;
        end
      end
      PEND: begin
        // Acknowledge beats a same-cycle higher-priority replacement.
        if (int_ack) state_nxt = SERV;
        else if (accept && (code_s > int_vec)) load_vec = 1'b1;
      end
      SERV: begin
        if (int_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    int_req    = 1'b0;
    in_service = 1'b0;
    case (state)
      PEND:    int_req    = 1'b1;
      SERV:    in_service = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_irq_dispatch.sv
// Directed bench for irq_dispatch with a rule-level reference model checked every cycle.
module tb_irq_dispatch;

`ifdef IRQ_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int LAT  = 4;
`else
  localparam bit FILT = 1'b0;
  localparam int LAT  = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_bar;
  logic       GS_bar;
  logic [2:0] Y_bar;
  logic       int_ack;
  logic       int_done;
  logic       int_req;
  logic [2:0] int_vec;
  logic       in_service;

  int n_chk  = 0;
  int n_pass = 0;

  irq_dispatch dut (
    .clk       (clk),
    .rst_bar   (rst_bar),
    .GS_bar    (GS_bar),
    .Y_bar     (Y_bar),
    .int_ack   (int_ack),
    .int_done  (int_done),
    .int_req   (int_req),
    .int_vec   (int_vec),
    .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: inputs seen by the dispatcher at edge k are those present at edge k-2.
  logic [3:0] hist[$];
  int         edge_k = 0;
  int         done_edge;
  bit         m_req, m_srv;
  logic [2:0] m_vec;
  logic [3:0] cur, prv;
  bit         acc;
  logic [2:0] code;

  task automatic m_clear();
    hist      = '{4'hF, 4'hF, 4'hF};
    m_req     = 1'b0;
    m_srv     = 1'b0;
    m_vec     = 3'd0;
    done_edge = -100;
  endtask

  always @(negedge rst_bar) m_clear();

  always @(posedge clk) begin
    edge_k++;
    if (!rst_bar) begin
      m_clear();
    end else begin
      cur  = hist[hist.size()-2];
      prv  = hist[hist.size()-3];
      acc  = !cur[3] && (!FILT || (cur == prv));
      code = ~cur[2:0];
      if (m_srv) begin
        if (int_done) begin
          m_srv     = 1'b0;
          done_edge = edge_k;
        end
      end else if (m_req) begin
        if (int_ack) begin
          m_req = 1'b0;
          m_srv = 1'b1;
        end else if (acc && code > m_vec) begin
          m_vec = code;
        end
      end else if (acc && edge_k >= done_edge + 2) begin
        m_req = 1'b1;
        m_vec = code;
      end
      hist.push_back({GS_bar, Y_bar});
      if (hist.size() > 6) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    chk("model_int_req", int'(int_req), int'(m_req));
    chk("model_in_service", int'(in_service), int'(m_srv));
    chk("model_int_vec", int'(int_vec), int'(m_vec));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic service();
    int_ack = 1'b1;
    step(1);
    int_ack  = 1'b0;
    int_done = 1'b1;
    step(1);
    int_done = 1'b0;
    step(3);
  endtask

  initial begin
    rst_bar  = 1'b0;
    GS_bar   = 1'b0;
    Y_bar    = 3'b010;
    int_ack  = 1'b0;
    int_done = 1'b0;
    step(3);
    chk("rst_req", int'(int_req), 0);
    chk("rst_vec", int'(int_vec), 0);
    chk("rst_srv", int'(in_service), 0);

    rst_bar = 1'b1;
    step(LAT - 1);
    chk("lat_req_early", int'(int_req), 0);
    step(1);
    chk("lat_req", int'(int_req), 1);
    chk("lat_vec", int'(int_vec), 5);

    int_ack = 1'b1;
    step(1);
    chk("ack_srv", int'(in_service), 1);
    chk("ack_req", int'(int_req), 0);
    step(1);
    int_ack  = 1'b0;
    GS_bar   = 1'b1;
    int_done = 1'b1;
    step(1);
    int_done = 1'b0;
    chk("done_srv", int'(in_service), 0);
    step(4);

    GS_bar = 1'b0;
    Y_bar  = ~3'd2;
    step(LAT);
    chk("pend_vec2", int'(int_vec), 2);
    Y_bar = ~3'd6;
    step(LAT);
    chk("repl_vec6", int'(int_vec), 6);
    chk("repl_req", int'(int_req), 1);
    Y_bar = ~3'd1;
    step(LAT + 1);
    chk("lower_ignored", int'(int_vec), 6);

    Y_bar = ~3'd7;
    step(LAT - 1);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    chk("ack_wins_srv", int'(in_service), 1);
    chk("ack_wins_vec", int'(int_vec), 6);
    step(3);
    chk("serv_ignore_vec", int'(int_vec), 6);

    int_done = 1'b1;
    step(1);
    int_done = 1'b0;
    chk("redo_srv_low", int'(in_service), 0);
    step(1);
    chk("redo_idle_gap", int'(int_req), 0);
    step(1);
    chk("redo_req", int'(int_req), 1);
    chk("redo_vec7", int'(int_vec), 7);

    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    chk("serv_before_rst", int'(in_service), 1);
    #2 rst_bar = 1'b0;
    #1;
    chk("async_rst_req", int'(int_req), 0);
    chk("async_rst_srv", int'(in_service), 0);
    chk("async_rst_vec", int'(int_vec), 0);
    @(negedge clk);
    rst_bar = 1'b1;
    GS_bar  = 1'b1;
    step(2);
    chk("post_rst_req", int'(int_req), 0);
    GS_bar = 1'b0;
    Y_bar  = ~3'd3;
    step(LAT);
    chk("post_rst_idle_req", int'(int_req), 1);
    chk("post_rst_idle_vec", int'(int_vec), 3);
    GS_bar = 1'b1;
    service();

    GS_bar = 1'b0;
    Y_bar  = ~3'd4;
    step(1);
    GS_bar = 1'b1;
    Y_bar  = 3'b111;
    step(LAT - 1);
`ifdef IRQ_FILTER_EN
    chk("glitch_rejected", int'(int_req), 0);
`else
    chk("pulse_accepted", int'(int_req), 1);
`endif
    service();

    GS_bar = 1'b0;
    Y_bar  = ~3'd4;
    step(2);
    GS_bar = 1'b1;
    Y_bar  = 3'b111;
    step(LAT - 2);
    chk("pulse2_req", int'(int_req), 1);
    chk("pulse2_vec", int'(int_vec), 4);
    service();

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
